// File: rtl/mshr_lb_ctrl_pkg.sv
// Shared bus parameters and line-buffer request payloads used by mshr_lb_ctrl.
// LB_LINES/LB_BEATS fix the 4x4 line-buffer geometry.
package BundleParam;
  localparam int unsigned dataBits = 32;
endpackage

package MSHRST;
  localparam int unsigned LB_LINES  = 4;
  localparam int unsigned LB_BEATS  = 4;
  localparam int unsigned LB_ID_W   = 2;
  localparam int unsigned LB_OFF_W  = 2;
  localparam int unsigned LB_ADDR_W = LB_ID_W + LB_OFF_W;
  localparam int unsigned LB_DATA_W = BundleParam::dataBits;

  typedef struct packed {
    logic [LB_ID_W-1:0]   id;
    logic [LB_OFF_W-1:0]  offset;
    logic [LB_DATA_W-1:0] data;
  } LineBufferWriteReqST;

  typedef struct packed {
    logic [LB_ID_W-1:0]  id;
    logic [LB_OFF_W-1:0] offset;
  } LineBufferReadReqST;

  // Flat beat address: line id in the upper bits, beat offset in the lower bits.
  function automatic logic [LB_ADDR_W-1:0] lb_addr(input logic [LB_ID_W-1:0] id,
                                                    input logic [LB_OFF_W-1:0] offset);
    return {id, offset};
  endfunction
endpackage

// File: rtl/mshr_lb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// ptr moves to just past the winner on a grant and holds otherwise.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt_c
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_c   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = PTR_W'((32'(idx) + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/mshr_lb_ctrl.sv
// MSHR refill line buffer: 4 lines x 4 beats, write-priority single-port storage,
// round-robin read service. Define LB_WR_FWD_EN to forward same-cycle write data to a matching read.
module mshr_lb_ctrl
  import MSHRST::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = BundleParam::dataBits
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  LineBufferWriteReqST              wr_req,
  input  logic [NREQ-1:0]                  rd_valid,
  output logic [NREQ-1:0]                  rd_ready,
  input  LineBufferReadReqST [NREQ-1:0]    rd_req,
  output logic                             resp_valid,
  output logic [$clog2(NREQ)-1:0]          resp_idx,
  output logic [DATA_W-1:0]                resp_data,
  input  logic                             clr_valid,
  input  logic [LB_ID_W-1:0]               clr_id,
  output logic [LB_LINES-1:0]              line_full,
  output logic                             err_overwrite
);
  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned NBEAT = LB_LINES * LB_BEATS;

  logic [DATA_W-1:0]    mem [NBEAT];
  logic [NBEAT-1:0]     beat_vld;
  logic [NBEAT-1:0]     beat_vld_nxt;
  logic [LB_ADDR_W-1:0] wr_addr;
  logic [LB_ADDR_W-1:0] rd_addr [NREQ];
  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [LB_ADDR_W-1:0] sel_addr;

  assign wr_ready = 1'b1;
  assign wr_addr  = lb_addr(wr_req.id, wr_req.offset);

  // Eligibility: beat valid, no write this cycle (unless forwarding), no clear of the same line.
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    logic clr_blk;
    assign rd_addr[i] = lb_addr(rd_req[i].id, rd_req[i].offset);
    assign clr_blk    = clr_valid && (clr_id == rd_req[i].id);
`ifdef LB_WR_FWD_EN
    assign elig[i] = rd_valid[i] && !clr_blk &&
                     (wr_valid ? (rd_addr[i] == wr_addr) : beat_vld[rd_addr[i]]);
`else
    assign elig[i] = rd_valid[i] && !clr_blk && !wr_valid && beat_vld[rd_addr[i]];
`endif
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (elig),
    .gnt_c   (gnt)
  );

  assign rd_ready = gnt;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign sel_addr = rd_addr[gnt_idx];

  // Clear first, then the write: a write to a line being cleared survives.
  always_comb begin
    beat_vld_nxt = beat_vld;
    if (clr_valid) begin
      for (int unsigned b = 0; b < LB_BEATS; b++) begin
        beat_vld_nxt[lb_addr(clr_id, LB_OFF_W'(b))] = 1'b0;
      end
    end
    if (wr_valid) beat_vld_nxt[wr_addr] = 1'b1;
  end

  for (genvar l = 0; l < LB_LINES; l++) begin : g_full
    assign line_full[l] = &beat_vld[l*LB_BEATS +: LB_BEATS];
  end

  always_ff @(posedge clock) begin
    if (wr_valid) mem[wr_addr] <= DATA_W'(wr_req.data);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_vld      <= '0;
      resp_valid    <= 1'b0;
      resp_idx      <= '0;
      resp_data     <= '0;
      err_overwrite <= 1'b0;
    end else begin
      beat_vld      <= beat_vld_nxt;
      err_overwrite <= wr_valid && beat_vld[wr_addr];
      resp_valid    <= |gnt;
      if (|gnt) begin
        resp_idx <= gnt_idx;
`ifdef LB_WR_FWD_EN
        resp_data <= wr_valid ? DATA_W'(wr_req.data) : mem[sel_addr];
`else
        resp_data <= mem[sel_addr];
`endif
      end
    end
  end
endmodule

// File: doc/mshr_lb_ctrl.md
MSHR_LB_CTRL -- requirements
Module: mshr_lb_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of read requesters.
REQ-002 SHALL have parameter DATA_W, default BundleParam::dataBits, beat width.
REQ-003 SHALL have ports `clock`, input, 1, sole clock; `reset_n`, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports `wr_valid`, input, 1; `wr_ready`, output, 1; `wr_req`, input, LineBufferWriteReqST, refill beat (id, offset, data).
REQ-005 SHALL have ports `rd_valid`, input, NREQ; `rd_ready`, output, NREQ; `rd_req`, input, NREQ x LineBufferReadReqST.
REQ-006 SHALL have ports `resp_valid`, output, 1; `resp_idx`, output, clog2(NREQ), requester served; `resp_data`, output, DATA_W.
REQ-007 SHALL have ports `clr_valid`, input, 1; `clr_id`, input, 2, release line.
REQ-008 SHALL have ports `line_full`, output, 4, per-line all beats valid; `err_overwrite`, output, 1, pulse.

Function
REQ-009 SHALL own storage of 4 lines x 4 beats x DATA_W, single access per cycle, plus beat_vld[4][4].
REQ-010 SHALL hold `wr_ready`=1 always; a write is accepted when `wr_valid`=1, storing data and setting beat_vld[id][offset] on the next edge.
REQ-011 SHALL pulse `err_overwrite` for one cycle, one cycle after accepting a write whose beat_vld bit was already 1; data is still overwritten.
REQ-012 SHALL treat requester i as eligible when rd_valid[i]=1 and beat_vld[rd_req[i].id][rd_req[i].offset]=1.
REQ-013 SHALL grant no read in a cycle with an accepted write (write priority), except per REQ-024.
REQ-014 SHALL grant at most one eligible requester per cycle, round-robin starting at pointer ptr; rd_ready is combinational, one-hot or zero.
REQ-015 SHALL advance ptr to (granted index + 1) mod NREQ on a grant and hold it otherwise.
REQ-016 SHALL assert `resp_valid` exactly one cycle after a grant, with `resp_idx` equal to the granted index and `resp_data` equal to the stored beat. It SHALL deassert `resp_valid` when there was no grant.
REQ-017 SHALL NOT back-pressure responses; requesters consume `resp_*` in the valid cycle.
REQ-018 SHALL clear beat_vld[clr_id][*] on the edge after `clr_valid`=1.
REQ-019 SHALL give write precedence over clear when both target the same id in the same cycle: the result is cleared line plus the written beat valid.
REQ-020 SHALL block a read from being granted in the same cycle as a clear of its id.
REQ-021 SHALL drive `line_full[id]` = AND of beat_vld[id][*] (registered state, no same-cycle write lookahead).

Reset
REQ-022 SHALL, while reset_n=0: beat_vld=0, ptr=0, resp_valid=0, resp_idx=0, resp_data=0, err_overwrite=0, line_full=0. Storage data is not reset.
REQ-023 SHALL drop any grant in flight when reset asserts mid-operation; no response appears after reset release.

Configuration
REQ-024 SHALL, with `LB_WR_FWD_EN` defined, let a read matching the same-cycle write id/offset be eligible and grantable alongside the write. Its response data is the write data, and the bypass applies even if the beat was previously invalid.
REQ-025 SHALL, without `LB_WR_FWD_EN`, apply REQ-013 strictly: no reads granted in write cycles.

Structure
REQ-026 SHALL reuse LineBufferWriteReqST/LineBufferReadReqST from package MSHRST. It SHALL add the constants LB_LINES=4 and LB_BEATS=4 to that package.
REQ-027 SHALL place the round-robin selection in sub-module `rr_arbiter` (NREQ-wide request in, one-hot grant out, ptr register inside).

Verification
REQ-028 SHALL cover: writes id=1 offsets 0..3 with data 0xA0..0xA3 -> line_full=4'b0010 after 4th write+1 cycle.
REQ-029 SHALL cover: all 4 requesters read id=1 off=2 continuously from ptr=0 -> grants 0,1,2,3,0 in consecutive cycles; each resp_data=0xA2 one cycle later.
REQ-030 SHALL cover: requester 2 reads id=0 off=0 before it is written -> rd_ready[2]=0 until write accepted. Then it is granted the cycle after the write (no FWD), or the same cycle with resp_data=write data (FWD).
REQ-031 SHALL cover: write id=3 off=1 twice -> err_overwrite=1 exactly once, one cycle after the second write; the later data is returned.
REQ-032 SHALL cover: clr_id=1 with simultaneous write id=1 off=3 -> beat_vld[1]=4'b1000, line_full[1]=0, read of off=0 not granted.
REQ-033 SHALL cover: reset_n pulsed low the cycle after a grant -> resp_valid=0, line_full=0, ptr=0 after release.
